mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage_data_mem.sv | 29 ++
 rtl/mem_stage.sv | 114 +++++++++++
 tb/tb_mem_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: WB control layout and datapath widths.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef logic [1:0] wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = 2'b00;

  // A word access must have its two byte-offset bits clear.
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage bundled as one interface.
interface mem_stage_if;
  import mem_stage_pkg::*;

  wb_ctrl_t            ex_control_wb;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic [DATA_W-1:0]   ex_alu_result;
  logic [DATA_W-1:0]   ex_write_data;
  logic [REG_W-1:0]    ex_write_reg;

  wb_ctrl_t            mem_control_wb;
  logic [DATA_W-1:0]   mem_read_data;
  logic [DATA_W-1:0]   mem_alu_result;
  logic [REG_W-1:0]    mem_write_reg;

  modport master (
    output ex_control_wb, ex_mem_read, ex_mem_write, ex_alu_result, ex_write_data, ex_write_reg,
    input  mem_control_wb, mem_read_data, mem_alu_result, mem_write_reg
  );

  modport slave (
    input  ex_control_wb, ex_mem_read, ex_mem_write, ex_alu_result, ex_write_data, ex_write_reg,
    output mem_control_wb, mem_read_data, mem_alu_result, mem_write_reg
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-wide data memory: synchronous write, asynchronous read.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    ADDR_BITS   = 8,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  // Store port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_mem[i_addr] <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access, MEM/WB pipeline register and sticky address-fault flags.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    ADDR_BITS   = 8,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        err_clear,
  mem_stage_if.slave  bus,
  output logic        misalign_err,
  output logic        range_err
);

  logic              w_access;
  logic              w_misalign;
  logic              w_out_of_range;
  logic              w_addr_ok;
  logic              w_we;
  logic              w_normal;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_load_data;
  wb_ctrl_t          w_ctrl_next;

  wb_ctrl_t          r_control_wb;
  logic [DATA_W-1:0] r_read_data;
  logic [DATA_W-1:0] r_alu_result;
  logic [REG_W-1:0]  r_write_reg;
  logic              r_misalign_err;
  logic              r_range_err;

  assign w_access       = bus.ex_mem_read | bus.ex_mem_write;
  assign w_misalign     = is_misaligned(bus.ex_alu_result);
  assign w_out_of_range = (bus.ex_alu_result[DATA_W-1:ADDR_BITS+2] != '0);
  assign w_addr_ok      = ~w_misalign & ~w_out_of_range;
  assign w_normal       = ~stall & ~flush;
  assign w_we           = bus.ex_mem_write & w_addr_ok & w_normal & rst_n;

  data_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (ADDR_BITS),
    .INIT_FILE   (INIT_FILE)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (bus.ex_alu_result[ADDR_BITS+1:2]),
    .i_wdata (bus.ex_write_data),
    .o_rdata (w_mem_rdata)
  );

  // A faulting access must not commit, so RegWrite is dropped while the other fields pass.
  always_comb begin
    w_load_data = 32'h0000_0000;
    w_ctrl_next = bus.ex_control_wb;
    if (bus.ex_mem_read && w_addr_ok) begin
      w_load_data = w_mem_rdata;
    end else begin
      w_load_data = 32'h0000_0000;
    end
    if (w_access && !w_addr_ok) begin
      w_ctrl_next[WB_REGWRITE] = 1'b0;
    end else begin
      w_ctrl_next = bus.ex_control_wb;
    end
  end

  // MEM/WB register: reset > flush > stall > normal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_control_wb <= WB_BUBBLE;
      r_read_data  <= 32'h0000_0000;
      r_alu_result <= 32'h0000_0000;
      r_write_reg  <= 5'd0;
    end else if (flush) begin
      r_control_wb <= WB_BUBBLE;
      r_read_data  <= 32'h0000_0000;
      r_alu_result <= 32'h0000_0000;
      r_write_reg  <= 5'd0;
    end else if (stall) begin
      r_control_wb <= r_control_wb;
      r_read_data  <= r_read_data;
      r_alu_result <= r_alu_result;
      r_write_reg  <= r_write_reg;
    end else begin
      r_control_wb <= w_ctrl_next;
      r_read_data  <= w_load_data;
      r_alu_result <= bus.ex_alu_result;
      r_write_reg  <= bus.ex_write_reg;
    end
  end

  // Sticky fault flags; a new fault in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
      r_range_err    <= 1'b0;
    end else begin
      r_misalign_err <= (w_normal & w_access & w_misalign)     | (r_misalign_err & ~err_clear);
      r_range_err    <= (w_normal & w_access & w_out_of_range) | (r_range_err & ~err_clear);
    end
  end

  assign bus.mem_control_wb = r_control_wb;
  assign bus.mem_read_data  = r_read_data;
  assign bus.mem_alu_result = r_alu_result;
  assign bus.mem_write_reg  = r_write_reg;
  assign misalign_err       = r_misalign_err;
  assign range_err          = r_range_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: driver queues hand-computed MEM/WB results, monitor checks them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [1:0]  cwb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        mis;
    logic        rng;
  } exp_t;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  logic err_clear;
  logic misalign_err;
  logic range_err;

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH_WORDS (256),
    .ADDR_BITS   (8),
    .INIT_FILE   ("")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .err_clear    (err_clear),
    .bus          (bus),
    .misalign_err (misalign_err),
    .range_err    (range_err)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: each edge after the driver queued a vector, the MEM/WB outputs are compared.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem_control_wb", {30'd0, bus.mem_control_wb}, {30'd0, e.cwb});
      chk("mem_read_data",  bus.mem_read_data,           e.rdata);
      chk("mem_alu_result", bus.mem_alu_result,          e.alu);
      chk("mem_write_reg",  {27'd0, bus.mem_write_reg},  {27'd0, e.wreg});
      chk("misalign_err",   {31'd0, misalign_err},       {31'd0, e.mis});
      chk("range_err",      {31'd0, range_err},          {31'd0, e.rng});
    end
  end

  task automatic step(
    input logic rn, input logic st, input logic fl, input logic clr,
    input logic rd, input logic wr, input logic [1:0] cwb,
    input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
    input logic [1:0] e_cwb, input logic [31:0] e_rd, input logic [31:0] e_alu,
    input logic [4:0] e_reg, input logic e_mis, input logic e_rng);
    exp_t e;
    @(negedge clk);
    rst_n                = rn;
    stall                = st;
    flush                = fl;
    err_clear            = clr;
    bus.ex_mem_read      = rd;
    bus.ex_mem_write     = wr;
    bus.ex_control_wb    = cwb;
    bus.ex_alu_result    = alu;
    bus.ex_write_data    = wd;
    bus.ex_write_reg     = wreg;
    e.cwb   = e_cwb;
    e.rdata = e_rd;
    e.alu   = e_alu;
    e.wreg  = e_reg;
    e.mis   = e_mis;
    e.rng   = e_rng;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; err_clear = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0; bus.ex_control_wb = 2'b00;
    bus.ex_alu_result = 32'h0; bus.ex_write_data = 32'h0; bus.ex_write_reg = 5'd0;

    //    rn    st    fl    clr   rd    wr    cwb    alu           wd            reg     e_cwb  e_rd          e_alu         e_reg  mis   rng
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0040, 32'h1111_1111, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0040, 5'd0, 1'b0, 1'b0);
    // store attempts during reset must not land
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_0040, 32'hDEAD_BEEF, 5'd3,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_0040, 32'hDEAD_BEEF, 5'd3,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0040, 32'h0000_0000, 5'd9,  2'b11, 32'h1111_1111, 32'h0000_0040, 5'd9, 1'b0, 1'b0);
    // store then load
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'hAAAA_AAAA, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0010, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h0000_0000, 5'd8,  2'b11, 32'hAAAA_AAAA, 32'h0000_0010, 5'd8, 1'b0, 1'b0);
    // ALU passthrough, no access
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h5555_5555, 32'h0000_0000, 5'd4,  2'b01, 32'h0000_0000, 32'h5555_5555, 5'd4, 1'b0, 1'b0);
    // stall holds outputs and suppresses stores
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'hCAFE_F00D, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0020, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h0000_0000, 5'd7,  2'b11, 32'hAAAA_AAAA, 32'h0000_0010, 5'd7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0020, 32'h1234_5678, 5'd2,  2'b11, 32'hAAAA_AAAA, 32'h0000_0010, 5'd7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0020, 32'h1234_5678, 5'd2,  2'b11, 32'hAAAA_AAAA, 32'h0000_0010, 5'd7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0021, 32'h1234_5678, 5'd2,  2'b11, 32'hAAAA_AAAA, 32'h0000_0010, 5'd7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'h0000_0000, 5'd5,  2'b11, 32'hCAFE_F00D, 32'h0000_0020, 5'd5, 1'b0, 1'b0);
    // flush wins over stall and also suppresses stores
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h0000_0000, 5'd6,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0020, 32'hBADB_AD00, 5'd6,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'h0000_0000, 5'd5,  2'b11, 32'hCAFE_F00D, 32'h0000_0020, 5'd5, 1'b0, 1'b0);
    // misaligned load: RegWrite dropped, flag sticky, set beats clear
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0013, 32'h0000_0000, 5'd8,  2'b10, 32'h0000_0000, 32'h0000_0013, 5'd8, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0013, 32'h0000_0000, 5'd8,  2'b10, 32'h0000_0000, 32'h0000_0013, 5'd8, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    // out-of-range store must not alias onto word 0
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0000_0A0A, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0400, 32'hFFFF_FFFF, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_0400, 5'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0000, 32'h0000_0000, 5'd1,  2'b11, 32'h0000_0A0A, 32'h0000_0000, 5'd1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_03FC, 32'h7654_3210, 5'd0,  2'b00, 32'h0000_0000, 32'h0000_03FC, 5'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_03FC, 32'h0000_0000, 5'd2,  2'b11, 32'h7654_3210, 32'h0000_03FC, 5'd2, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h0000_0000, 5'd3,  2'b10, 32'h0000_0000, 32'h0000_0400, 5'd3, 1'b0, 1'b1);
    // read+write together: store happens, load returns the old word
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 32'h0000_03FC, 32'h0F0F_0F0F, 5'd4,  2'b11, 32'h7654_3210, 32'h0000_03FC, 5'd4, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_03FC, 32'h0000_0000, 5'd4,  2'b11, 32'h0F0F_0F0F, 32'h0000_03FC, 5'd4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_03FC, 32'h0000_0000, 5'd4,  2'b00, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
